// File: rtl/tl_ul_pkg.sv
// -----------------------------------------------------------------------------
// tl_ul_pkg
//   Shared TileLink-UL definitions for the RAM responder: opcode constants,
//   bus widths, A/D channel payload structs, the response-slot state type and
//   a small alignment helper.
//   Source IDs are not part of the structs because their width is a module
//   parameter; they travel next to the struct wherever a struct is used.
// -----------------------------------------------------------------------------
package tl_ul_pkg;

   // Bus widths
   localparam int unsigned TL_AW  = 30;  // byte address
   localparam int unsigned TL_DW  = 32;  // data
   localparam int unsigned TL_DBW = 4;   // byte lanes (mask)

   // A-channel opcodes
   localparam logic [2:0] PUT_FULL    = 3'd0;
   localparam logic [2:0] PUT_PARTIAL = 3'd1;
   localparam logic [2:0] GET         = 3'd4;

   // D-channel opcodes
   localparam logic [2:0] ACK      = 3'd0;
   localparam logic [2:0] ACK_DATA = 3'd1;

   typedef struct packed {
      logic [2:0]        opcode;
      logic [2:0]        size;
      logic [TL_AW-1:0]  address;
      logic [TL_DBW-1:0] mask;
      logic [TL_DW-1:0]  data;
      logic              corrupt;
   } a_chan_t;

   typedef struct packed {
      logic [2:0]       opcode;
      logic [2:0]       param;
      logic [2:0]       size;
      logic             denied;
      logic             corrupt;
      logic [TL_DW-1:0] data;
   } d_chan_t;

   // Occupancy of the single response register.
   typedef enum logic [0:0] {
      StIdle,
      StRsp
   } rsp_state_e;

   // True when the low address bits are aligned to a 2^size byte transfer.
   // Sizes above a word are never aligned for this 32-bit link.
   function automatic logic addr_aligned(input logic [1:0] lsb, input logic [2:0] size);
      logic ok;
      unique case (size)
         3'd0:    ok = 1'b1;
         3'd1:    ok = ~lsb[0];
         3'd2:    ok = (lsb == 2'b00);
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/tl_ul_ram_responder_if.sv
// -----------------------------------------------------------------------------
// tl_ul_ram_responder_if
//   One 32-bit TL-UL link (A request channel + D response channel).
//   Modports:
//     master - initiator side: drives A payload/valid and d_ready.
//     slave  - responder side: drives a_ready and the D payload/valid.
//   Parameter SRC_W: width of the source ID carried on a_source/d_source.
// -----------------------------------------------------------------------------
interface tl_ul_ram_responder_if
   import tl_ul_pkg::*;
#(
   parameter int unsigned SRC_W = 7
) ();

   // A channel
   logic              a_valid;
   logic              a_ready;
   logic [2:0]        a_opcode;
   logic [2:0]        a_param;
   logic [2:0]        a_size;
   logic [SRC_W-1:0]  a_source;
   logic [TL_AW-1:0]  a_address;
   logic [TL_DBW-1:0] a_mask;
   logic [TL_DW-1:0]  a_data;
   logic              a_corrupt;

   // D channel
   logic              d_valid;
   logic              d_ready;
   logic [2:0]        d_opcode;
   logic [2:0]        d_param;
   logic [2:0]        d_size;
   logic [SRC_W-1:0]  d_source;
   logic              d_denied;
   logic              d_corrupt;
   logic [TL_DW-1:0]  d_data;

   modport master (
      output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data,
             a_corrupt, d_ready,
      input  a_ready, d_valid, d_opcode, d_param, d_size, d_source, d_denied, d_corrupt,
             d_data
   );

   modport slave (
      input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data,
             a_corrupt, d_ready,
      output a_ready, d_valid, d_opcode, d_param, d_size, d_source, d_denied, d_corrupt,
             d_data
   );

endinterface

// File: rtl/tl_ul_ram_bytewrite.sv
// -----------------------------------------------------------------------------
// tl_ul_ram_bytewrite
//   2^DEPTH_LOG2 x 32-bit storage with a combinational read port and a
//   synchronous write port with one enable per byte lane. Contents are not
//   reset.
//   Ports:
//     clock  - write clock
//     waddr  - write word index
//     wbe    - byte-lane write enables (all zero = no write)
//     wdata  - write data
//     raddr  - read word index
//     rdata  - read data, combinational from raddr
// -----------------------------------------------------------------------------
module tl_ul_ram_bytewrite
   import tl_ul_pkg::*;
#(
   parameter int unsigned DEPTH_LOG2 = 8
) (
   input  logic                  clock,
   input  logic [DEPTH_LOG2-1:0] waddr,
   input  logic [TL_DBW-1:0]     wbe,
   input  logic [TL_DW-1:0]      wdata,
   input  logic [DEPTH_LOG2-1:0] raddr,
   output logic [TL_DW-1:0]      rdata
);

   localparam int unsigned Depth = 1 << DEPTH_LOG2;

   logic [TL_DW-1:0] mem [Depth];

   always_ff @(posedge clock) begin
      for (int i = 0; i < TL_DBW; i++) begin
         if (wbe[i]) begin
            mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

   // Asynchronous read: a read of the word being written this cycle sees the
   // old contents, the new value is visible from the next cycle.
   assign rdata = mem[raddr];

endmodule

// File: rtl/tl_ul_ram_responder.sv
// -----------------------------------------------------------------------------
// tl_ul_ram_responder
//   TL-UL manager end serving Get / PutFullData / PutPartialData from a local
//   word-addressed RAM. One response register gives single-cycle latency and
//   one request per cycle throughput; illegal requests are answered with
//   d_denied set and never touch the RAM.
//   Parameters:
//     DEPTH_LOG2 - log2 of RAM depth in 32-bit words
//     BASE_ADDR  - byte base address of the window (aligned to 4 << DEPTH_LOG2)
//     SRC_W      - source ID width (must match the interface)
//   Ports:
//     clock   - sole clock
//     reset_n - asynchronous active-low reset; clears the response register
//     bus     - TL-UL link, slave modport (A in, D out)
// -----------------------------------------------------------------------------
module tl_ul_ram_responder
   import tl_ul_pkg::*;
#(
   parameter int unsigned DEPTH_LOG2 = 8,
   parameter logic [29:0] BASE_ADDR  = 30'h0,
   parameter int unsigned SRC_W      = 7
) (
   input  logic                        clock,
   input  logic                        reset_n,
   tl_ul_ram_responder_if.slave        bus
);

   // Window size in bytes, one bit wider than the address so BASE + size
   // cannot wrap at the top of the address space.
   localparam logic [TL_AW:0] WinBytes = (TL_AW + 1)'(1) << (DEPTH_LOG2 + 2);

   // ---------------------------------------------------------------------------
   // Request capture and decode
   // ---------------------------------------------------------------------------
   a_chan_t                a_req;
   logic                   fire;
   logic                   is_get;
   logic                   legal_op;
   logic                   in_range;
   logic                   aligned;
   logic                   legal;
   logic [TL_AW:0]         addr_ext;
   logic [TL_AW:0]         base_ext;
   logic [TL_AW-1:0]       offset;
   logic [DEPTH_LOG2-1:0]  word_idx;

   assign a_req.opcode  = bus.a_opcode;
   assign a_req.size    = bus.a_size;
   assign a_req.address = bus.a_address;
   assign a_req.mask    = bus.a_mask;
   assign a_req.data    = bus.a_data;
   assign a_req.corrupt = bus.a_corrupt;

   assign addr_ext = {1'b0, a_req.address};
   assign base_ext = {1'b0, BASE_ADDR};
   assign in_range = (addr_ext >= base_ext) && (addr_ext < (base_ext + WinBytes));

   // Only meaningful when in_range; out-of-range requests never reach the RAM.
   assign offset   = a_req.address - BASE_ADDR;
   assign word_idx = DEPTH_LOG2'(offset >> 2);

   assign is_get   = (a_req.opcode == GET);
   assign legal_op = (a_req.opcode == PUT_FULL) || (a_req.opcode == PUT_PARTIAL) || is_get;
   assign aligned  = addr_aligned(a_req.address[1:0], a_req.size);
   assign legal    = in_range && legal_op && (a_req.size <= 3'd2) && aligned;

   // ---------------------------------------------------------------------------
   // Storage
   // ---------------------------------------------------------------------------
   logic [TL_DBW-1:0] ram_wbe;
   logic [TL_DW-1:0]  ram_rdata;

   // Poisoned write data suppresses every lane but is still acknowledged.
   assign ram_wbe = (fire && legal && !is_get && !a_req.corrupt) ? a_req.mask : '0;

   tl_ul_ram_bytewrite #(
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_ram (
      .clock (clock),
      .waddr (word_idx),
      .wbe   (ram_wbe),
      .wdata (a_req.data),
      .raddr (word_idx),
      .rdata (ram_rdata)
   );

   // ---------------------------------------------------------------------------
   // Response formation
   // ---------------------------------------------------------------------------
   d_chan_t rsp_d;

   always_comb begin
      rsp_d      = '0;
      rsp_d.size = a_req.size;
      if (!legal) begin
         rsp_d.denied = 1'b1;
         if (is_get) begin
            rsp_d.opcode  = ACK_DATA;
            rsp_d.corrupt = 1'b1;
         end else begin
            rsp_d.opcode = ACK;
         end
      end else if (is_get) begin
         rsp_d.opcode = ACK_DATA;
         rsp_d.data   = ram_rdata;
      end else begin
         rsp_d.opcode = ACK;
      end
   end

   // ---------------------------------------------------------------------------
   // Response register: StRsp while a response is being offered on D
   // ---------------------------------------------------------------------------
   rsp_state_e        state_q, state_d;
   d_chan_t           rsp_q;
   logic [SRC_W-1:0]  src_q;
   logic              d_valid;

   assign d_valid  = (state_q == StRsp);
   // The slot can take a new request whenever it is empty or being drained.
   assign fire     = bus.a_valid && bus.a_ready;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: if (fire) state_d = StRsp;
         StRsp:  if (!fire && bus.d_ready) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StIdle;
         rsp_q   <= '0;
         src_q   <= '0;
      end else begin
         state_q <= state_d;
         if (fire) begin
            rsp_q <= rsp_d;
            src_q <= bus.a_source;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign bus.a_ready   = !d_valid || bus.d_ready;
   assign bus.d_valid   = d_valid;
   assign bus.d_opcode  = rsp_q.opcode;
   assign bus.d_param   = rsp_q.param;
   assign bus.d_size    = rsp_q.size;
   assign bus.d_source  = src_q;
   assign bus.d_denied  = rsp_q.denied;
   assign bus.d_corrupt = rsp_q.corrupt;
   assign bus.d_data    = rsp_q.data;

   // a_param carries no meaning for this responder.
   logic unused_param;
   assign unused_param = ^bus.a_param;

endmodule

// File: tb/tb_tl_ul_ram_responder.sv
// -----------------------------------------------------------------------------
// tb_tl_ul_ram_responder
//   Self-checking bench for tl_ul_ram_responder. Requests are driven on the
//   falling edge; the expected response is computed from a reference memory
//   when a request is accepted, queued, and compared when the DUT hands the
//   response over on D.
// -----------------------------------------------------------------------------
module tb_tl_ul_ram_responder;
   import tl_ul_pkg::*;

   localparam int unsigned SrcW = 7;

   logic clock = 1'b0;
   logic reset_n = 1'b0;
   always #5 clock = ~clock;

   tl_ul_ram_responder_if #(.SRC_W(SrcW)) bus ();

   tl_ul_ram_responder #(
      .DEPTH_LOG2 (8),
      .BASE_ADDR  (30'h0),
      .SRC_W      (SrcW)
   ) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   typedef struct {
      logic [2:0]      opcode;
      logic [2:0]      size;
      logic [SrcW-1:0] source;
      logic            denied;
      logic            corrupt;
      logic [31:0]     data;
      int unsigned     cyc;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] model_mem [256];
   int unsigned n_checks = 0;
   int unsigned n_errors = 0;
   int unsigned cyc = 0;
   bit          head_seen = 0;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // Reference behaviour for one request, evaluated against model_mem before
   // the request's own write is applied.
   function automatic exp_t model_rsp(input logic [2:0] op, input logic [2:0] size,
                                      input logic [SrcW-1:0] src, input logic [29:0] addr);
      exp_t r;
      bit   legal_op;
      bit   algn;
      bit   legal;
      legal_op = (op == 3'd0) || (op == 3'd1) || (op == 3'd4);
      algn     = (size == 3'd0) || (size == 3'd1 && !addr[0]) ||
                 (size == 3'd2 && addr[1:0] == 2'b00);
      legal    = (addr < 30'h400) && legal_op && algn;
      r.size   = size;
      r.source = src;
      r.cyc    = 0;
      r.denied = !legal;
      if (op == 3'd4) begin
         r.opcode  = 3'd1;
         r.corrupt = !legal;
         r.data    = legal ? model_mem[addr[9:2]] : 32'h0;
      end else begin
         r.opcode  = 3'd0;
         r.corrupt = 1'b0;
         r.data    = 32'h0;
      end
      return r;
   endfunction

   // Response monitor, sampling well after the rising edge.
   always @(negedge clock) begin
      exp_t e;
      #2;
      if (reset_n && bus.d_valid) begin
         if (sb.size() == 0) begin
            check_eq("unexpected_rsp", 32'(bus.d_valid), 32'd0);
         end else begin
            if (!head_seen) begin
               check_eq("latency", cyc, sb[0].cyc + 1);
               head_seen = 1;
            end
            if (bus.d_ready) begin
               e = sb.pop_front();
               head_seen = 0;
               check_eq("d_opcode", 32'(bus.d_opcode), 32'(e.opcode));
               check_eq("d_param", 32'(bus.d_param), 32'd0);
               check_eq("d_size", 32'(bus.d_size), 32'(e.size));
               check_eq("d_source", 32'(bus.d_source), 32'(e.source));
               check_eq("d_denied", 32'(bus.d_denied), 32'(e.denied));
               check_eq("d_corrupt", 32'(bus.d_corrupt), 32'(e.corrupt));
               if (e.opcode == 3'd1) check_eq("d_data", bus.d_data, e.data);
            end
         end
      end
   end

   task automatic drive(input logic [2:0] op, input logic [2:0] size, input logic [SrcW-1:0] src,
                        input logic [29:0] addr, input logic [3:0] mask, input logic [31:0] data,
                        input logic corrupt);
      bus.a_valid   = 1'b1;
      bus.a_opcode  = op;
      bus.a_param   = 3'($urandom_range(0, 7));
      bus.a_size    = size;
      bus.a_source  = src;
      bus.a_address = addr;
      bus.a_mask    = mask;
      bus.a_data    = data;
      bus.a_corrupt = corrupt;
   endtask

   // Called on a falling edge with a request on A; returns on the falling edge
   // after the request was accepted.
   task automatic accept(output int waited);
      exp_t e;
      waited = 0;
      #1;
      while (!bus.a_ready && waited < 50) begin
         @(negedge clock);
         #1;
         waited++;
      end
      if (!bus.a_ready) begin
         check_eq("accept_timeout", 32'(bus.a_ready), 32'd1);
         bus.a_valid = 1'b0;
         return;
      end
      e = model_rsp(bus.a_opcode, bus.a_size, bus.a_source, bus.a_address);
      e.cyc = cyc;
      sb.push_back(e);
      if (!e.denied && bus.a_opcode != 3'd4 && !bus.a_corrupt) begin
         for (int i = 0; i < 4; i++) begin
            if (bus.a_mask[i]) model_mem[bus.a_address[9:2]][8*i +: 8] = bus.a_data[8*i +: 8];
         end
      end
      @(negedge clock);
   endtask

   task automatic send(input logic [2:0] op, input logic [2:0] size, input logic [SrcW-1:0] src,
                       input logic [29:0] addr, input logic [3:0] mask, input logic [31:0] data,
                       input logic corrupt);
      int w;
      drive(op, size, src, addr, mask, data, corrupt);
      accept(w);
   endtask

   task automatic idle();
      bus.a_valid = 1'b0;
      @(negedge clock);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int w;
      bus.a_valid   = 1'b0;
      bus.a_opcode  = 3'd0;
      bus.a_param   = 3'd0;
      bus.a_size    = 3'd0;
      bus.a_source  = '0;
      bus.a_address = '0;
      bus.a_mask    = 4'h0;
      bus.a_data    = 32'h0;
      bus.a_corrupt = 1'b0;
      bus.d_ready   = 1'b1;

      // Reset state
      repeat (3) @(negedge clock);
      #1;
      check_eq("rst_d_valid", 32'(bus.d_valid), 32'd0);
      check_eq("rst_a_ready", 32'(bus.a_ready), 32'd1);
      check_eq("rst_d_opcode", 32'(bus.d_opcode), 32'd0);
      check_eq("rst_d_source", 32'(bus.d_source), 32'd0);
      check_eq("rst_d_denied", 32'(bus.d_denied), 32'd0);
      check_eq("rst_d_data", bus.d_data, 32'd0);
      @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);

      // PutFull then Get of the same word, back to back
      send(PUT_FULL, 3'd2, 7'd5, 30'h10, 4'hF, 32'hDEADBEEF, 1'b0);
      send(GET, 3'd2, 7'd6, 30'h10, 4'hF, 32'h0, 1'b0);
      idle();

      // PutPartial on lanes 0 and 2
      send(PUT_PARTIAL, 3'd2, 7'd7, 30'h10, 4'b0101, 32'h11223344, 1'b0);
      send(GET, 3'd2, 7'd8, 30'h10, 4'hF, 32'h0, 1'b0);
      idle();

      // Stall: response held while d_ready is low, next request waits
      bus.d_ready = 1'b0;
      send(GET, 3'd2, 7'd9, 30'h10, 4'hF, 32'h0, 1'b0);
      drive(GET, 3'd2, 7'd10, 30'h10, 4'h0, 32'h0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         #1;
         check_eq("stall_a_ready", 32'(bus.a_ready), 32'd0);
         check_eq("stall_d_valid", 32'(bus.d_valid), 32'd1);
         check_eq("stall_d_source", 32'(bus.d_source), 32'd9);
         check_eq("stall_d_data", bus.d_data, 32'hDE22BE44);
         @(negedge clock);
      end
      bus.d_ready = 1'b1;
      accept(w);
      check_eq("stall_release_wait", 32'(w), 32'd0);
      idle();

      // Out-of-range and misaligned Gets, then confirm RAM untouched
      send(GET, 3'd2, 7'd11, 30'h400, 4'hF, 32'h0, 1'b0);
      send(GET, 3'd2, 7'd12, 30'h2, 4'hF, 32'h0, 1'b0);
      send(GET, 3'd2, 7'd13, 30'h10, 4'hF, 32'h0, 1'b0);
      idle();

      // Illegal opcode, poisoned put, empty mask, misaligned put at 0x20
      send(PUT_FULL, 3'd2, 7'd14, 30'h20, 4'hF, 32'hCAFEF00D, 1'b0);
      send(3'd3, 3'd2, 7'd15, 30'h20, 4'hF, 32'h12345678, 1'b0);
      send(PUT_FULL, 3'd2, 7'd16, 30'h20, 4'hF, 32'h0BADBAD0, 1'b1);
      send(PUT_PARTIAL, 3'd2, 7'd17, 30'h20, 4'h0, 32'hFFFFFFFF, 1'b0);
      send(PUT_PARTIAL, 3'd1, 7'd18, 30'h21, 4'h6, 32'h00AAAA00, 1'b0);
      send(PUT_PARTIAL, 3'd0, 7'd19, 30'h23, 4'h8, 32'h77000000, 1'b0);
      send(GET, 3'd2, 7'd20, 30'h20, 4'hF, 32'h0, 1'b0);
      idle();

      // Streaming: 16 puts then 16 gets back to back
      for (int i = 0; i < 16; i++) begin
         drive(PUT_FULL, 3'd2, SrcW'(i), 30'h100 + 30'(4 * i), 4'hF, $urandom, 1'b0);
         accept(w);
         check_eq("strm_put_wait", 32'(w), 32'd0);
      end
      for (int i = 0; i < 16; i++) begin
         drive(GET, 3'd2, SrcW'(16 + i), 30'h100 + 30'(4 * i), 4'hF, 32'h0, 1'b0);
         accept(w);
         check_eq("strm_get_wait", 32'(w), 32'd0);
      end
      idle();

      // Reset asserted mid-stream
      for (int i = 0; i < 5; i++) send(GET, 3'd2, SrcW'(40 + i), 30'h100 + 30'(4 * i), 4'hF, 32'h0, 1'b0);
      drive(GET, 3'd2, 7'd50, 30'h104, 4'hF, 32'h0, 1'b0);
      #3;
      reset_n = 1'b0;
      #1;
      check_eq("midrst_d_valid", 32'(bus.d_valid), 32'd0);
      check_eq("midrst_a_ready", 32'(bus.a_ready), 32'd1);
      sb.delete();
      head_seen = 0;
      bus.a_valid = 1'b0;
      @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
      send(GET, 3'd2, 7'd60, 30'h108, 4'hF, 32'h0, 1'b0);
      idle();

      // Drain
      for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clock);
      check_eq("drain", 32'(sb.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/tl_ul_ram_responder.md
Name: tl_ul_ram_responder

Overview:
- TileLink-UL responder (manager end) for one 32-bit TL-UL link. The link bundle is passed straight through from the initiator side by the existing pass-through wrapper.
- Accepts A-channel Get, PutFullData and PutPartialData requests.
- Services them from a local word-addressed RAM and returns AccessAck or AccessAckData on the D channel.
- Sits behind the crossbar as a scratchpad / eval target, with single-cycle latency and full throughput.

Parameters:
- DEPTH_LOG2, 8, log2 of RAM depth in 32-bit words (256 words, 1 KiB).
- BASE_ADDR, 30'h0, byte base address of the window; must be aligned to 4 << DEPTH_LOG2.
- SRC_W, 7, source ID width.

Ports:
- clock  in  1  sole clock.
- reset_n  in  1  asynchronous, active-low reset.
- a_valid  in  1  A-channel request valid.
- a_ready  out  1  A-channel request accepted when high with a_valid.
- a_opcode  in  3  0 = PutFullData, 1 = PutPartialData, 4 = Get; all others illegal.
- a_param  in  3  ignored.
- a_size  in  3  log2 of transfer bytes.
- a_source  in  SRC_W  request ID.
- a_address  in  30  byte address.
- a_mask  in  4  byte lanes.
- a_data  in  32  write data.
- a_corrupt  in  1  write data poisoned.
- d_valid  out  1  response valid.
- d_ready  in  1  response consumed when high with d_valid.
- d_opcode  out  3  0 = AccessAck, 1 = AccessAckData.
- d_param  out  3  always 0.
- d_size  out  3  echo of a_size.
- d_source  out  SRC_W  echo of a_source.
- d_denied  out  1  request rejected.
- d_corrupt  out  1  read data invalid.
- d_data  out  32  read data.

Behaviour:
- Reset values: d_valid = 0; all registered D fields = 0. a_ready is combinational and equals 1 out of reset. RAM contents are not reset.
- Reset is asynchronous assert and synchronous deassert, handled externally. Reset mid-transaction discards any pending response; no retry is issued.
- Handshake: a_ready = !d_valid || d_ready. The request fires when a_valid && a_ready. The response register loads on the firing edge, so d_valid rises the next cycle. Latency is 1 cycle; throughput is 1 request/cycle.
- d_valid clears only when d_ready is high and no new request fires in that cycle. D fields hold stable while d_valid && !d_ready.
- Address decode:
  - word index = (a_address - BASE_ADDR) >> 2.
  - in_range when a_address >= BASE_ADDR and a_address < BASE_ADDR + (4 << DEPTH_LOG2).
- Legality: legal = in_range, opcode ∈ {0, 1, 4}, a_size <= 2, and a_address aligned to 1 << a_size.
- Illegal request: no RAM access; d_denied = 1.
  - If the opcode is Get, the response is AccessAckData with d_corrupt = 1 and d_data = 0.
  - Otherwise the response is AccessAck with d_corrupt = 0.
- Get (legal): d_opcode = 1. d_data = RAM word read combinationally at accept and registered, so the response is the pre-write value if the same word is written in that same cycle. The full 32-bit word is returned regardless of mask. d_denied = 0, d_corrupt = 0.
- PutFullData / PutPartialData (legal): d_opcode = 0. Byte lanes with a_mask[i] = 1 are written on the firing edge. Mask 4'b0000 acks with no write.
  - If a_corrupt = 1, no bytes are written and d_denied = 0.
- A Get following a Put to the same word in back-to-back cycles returns the new data, because the write commits before the next accept.
- d_size and d_source are registered echoes of the accepted request. d_param is always 0.

Decomposition:
- Shared package tl_ul_pkg holds:
  - opcode constants: PUT_FULL = 3'd0, PUT_PARTIAL = 3'd1, GET = 3'd4, ACK = 3'd0, ACK_DATA = 3'd1;
  - the a-channel and d-channel struct typedefs;
  - width constants for address, data and mask.
- One sub-module, tl_ul_ram_bytewrite: a 2^DEPTH_LOG2 x 32 array with asynchronous read and 4 byte-enable synchronous writes.
- Legality check, decode and the D register live in the top module.

Test Plan:
- Reset, then PutFull addr 0x10, data 0xDEADBEEF, mask 0xF, source 5, then Get addr 0x10 source 6 -> d_opcode 0 / source 5, then d_opcode 1 / source 6 with d_data 0xDEADBEEF, each 1 cycle after accept, denied = 0.
- PutPartial addr 0x10, mask 0b0101, data 0x11223344 -> subsequent Get returns 0xDE22BE44.
- Stall: d_ready = 0 for 3 cycles with a_valid held -> a_ready = 0, D fields stable; d_ready = 1 -> both handshakes fire in the same cycle and the next response appears next cycle.
- Out-of-range Get at BASE + 0x400, and misaligned Get size 2 at 0x2 -> d_opcode 1, d_denied 1, d_corrupt 1, d_data 0; RAM unchanged.
- Illegal opcode 3, and PutFull with a_corrupt = 1 at 0x20 -> d_opcode 0 (denied = 1 for opcode 3, denied = 0 for corrupt); a later Get at 0x20 shows the old value.
- Streaming: 16 back-to-back Gets with d_ready = 1 -> 16 responses on consecutive cycles, sources in order; assert reset_n low mid-stream -> d_valid = 0 immediately, a_ready = 1.
